atm_txn_ctrl: RTL
=================

Name: atm_txn_ctrl

Overview:
Parametrised next-generation ATM transaction controller. It tracks a card session through PIN entry with a bounded retry count and card retention on lockout, then takes an amount request checked against balance and note granularity. It dispenses notes one at a time over a valid/ready handshake, writes back the new balance, and ejects the card. Inactivity timeout applies in both wait states. It sits between the card reader/keypad front end and the note dispenser and account store.

Parameters:
PIN_W, 16, PIN width in bits
AMT_W, 16, amount and balance width in bits
NOTE_SHIFT, 5, note value is 2**NOTE_SHIFT currency units
MAX_TRIES, 3, wrong-PIN attempts allowed before retention (must be >=1)
TIMEOUT_CYC, 1000, idle cycles allowed in WAIT_PIN/WAIT_AMT (must be >=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
card_inserted  in  1  level, card present in slot
card_pin  in  PIN_W  PIN read from card, stable while card_inserted
pin_valid  in  1  one-cycle strobe, pin_in is valid
pin_in  in  PIN_W  keypad PIN
amt_valid  in  1  one-cycle strobe, amt_in is valid
amt_in  in  AMT_W  requested amount
balance  in  AMT_W  current account balance
note_ready  in  1  dispenser accepts a note this cycle
note_valid  out  1  note request to dispenser
balance_wr  out  1  one-cycle write strobe
balance_new  out  AMT_W  balance minus amount, valid with balance_wr
pin_error  out  1  one-cycle pulse on wrong PIN
amt_error  out  1  one-cycle pulse on rejected amount
tries_left  out  $clog2(MAX_TRIES+1)  remaining PIN attempts
timeout  out  1  one-cycle pulse on inactivity timeout
eject  out  1  level, card being returned
card_retain  out  1  level, card being swallowed

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0 except tries_left=MAX_TRIES. Notes counter and timer are 0. Reset mid-dispense abandons remaining notes with no further balance write.
- States: IDLE, WAIT_PIN, WAIT_AMT, DISPENSE, EJECT, RETAIN. All outputs are registered, so pulses appear the cycle after the triggering input.
- IDLE: card_inserted=1 -> WAIT_PIN. tries_left reloads to MAX_TRIES. Timer clears.
- WAIT_PIN, priority order:
  - card_inserted=0 -> IDLE.
  - pin_valid with pin_in==card_pin -> WAIT_AMT. tries_left reloads. Timer clears.
  - pin_valid with mismatch -> pin_error pulse and tries_left-1. If the result is 0 -> RETAIN, otherwise stay. Timer clears.
  - Timer reaches TIMEOUT_CYC-1 -> timeout pulse, EJECT.
- WAIT_AMT, same priority order:
  - card_inserted=0 -> IDLE.
  - amt_valid: reject if amt_in==0, amt_in>balance, or amt_in[NOTE_SHIFT-1:0]!=0. A reject gives an amt_error pulse, the state stays, and the timer clears.
  - Accept: notes = amt_in>>NOTE_SHIFT, balance_new = balance-amt_in, balance_wr pulse (once per transaction), -> DISPENSE.
  - Timer expiry -> timeout pulse, EJECT.
- DISPENSE:
  - note_valid=1 while notes>0.
  - A transfer occurs when note_valid&&note_ready; notes then decrements.
  - The transfer of the last note -> EJECT with note_valid=0 the next cycle.
  - card_inserted and the timer are ignored.
  - A note_ready held high gives one note per cycle.
- EJECT: eject=1 until card_inserted=0 -> IDLE.
- RETAIN: card_retain=1 until card_inserted=0 -> IDLE. No eject.
- The timer runs only in WAIT_PIN/WAIT_AMT. It saturates and never wraps.
- Arithmetic is unsigned. balance_new never underflows because of the accept check. At amt_in==balance, balance_new=0.

Decomposition:
- Shared package atm_pkg:
  - atm_state_t enum (3-bit).
  - Function amt_ok(amt, bal, shift) returning accept/reject.
- Sub-module atm_timeout_timer:
  - Ports: clk, reset, run, clear, expired.
  - Parameter TIMEOUT_CYC.
  - Counter width $clog2(TIMEOUT_CYC).

Test Plan:
1. card_pin=16'h1234; insert card, pin_in=16'h1234, amt_in=96, balance=200, note_ready=1 -> balance_wr with balance_new=104, exactly 3 note_valid&&note_ready transfers on consecutive cycles, then eject=1 until card removed, then IDLE.
2. Three wrong PINs (16'h1111) -> three pin_error pulses with tries_left 2,1,0, then card_retain=1 and eject stays 0. Removing the card returns the block to IDLE with tries_left=3 after the next insert.
3. In WAIT_AMT, present amt_in=0, amt_in=300 with balance=200, and amt_in=50 -> three amt_error pulses, no balance_wr. Then amt_in=64 -> accepted, 2 notes.
4. TIMEOUT_CYC=8, no keypad input after insert -> timeout pulse 8 cycles after entering WAIT_PIN, then EJECT. A pin_valid on cycle 7 clears the timer and prevents the timeout.
5. DISPENSE with note_ready toggling 1,0,0,1,1 and 3 notes -> transfers only on the ready cycles. Card removal mid-dispense is ignored. Reset low mid-dispense -> next cycle IDLE, note_valid=0, no second balance_wr.
6. Card removed in the same cycle as a correct pin_valid -> IDLE, no transition to WAIT_AMT.

Source files
------------

// File: rtl/atm_txn_ctrl_pkg.sv
// Shared types and helpers for the ATM transaction controller.
// The amount check lives here so the controller and any future account logic agree on it.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PIN = 3'd1,
    ST_WAIT_AMT = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_EJECT    = 3'd4,
    ST_RETAIN   = 3'd5
  } atm_state_t;

  // Accept only a non-zero, covered amount that is a whole number of notes.
  function automatic logic amt_ok(input logic [31:0] amt, input logic [31:0] bal,
                                  input int unsigned shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (amt != 32'd0) && (amt <= bal) && ((amt & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// Inactivity timer: counts while run is high, saturates at TIMEOUT_CYC-1,
// and flags expiry when the last count is reached.
module atm_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Saturating idle counter; clear wins over run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM session controller: PIN check with retention, amount check, note-by-note
// dispense over valid/ready, balance write-back and card eject. All outputs registered.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W       = 16,
  parameter int AMT_W       = 16,
  parameter int NOTE_SHIFT  = 5,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             card_inserted,
  input  logic [PIN_W-1:0]                 card_pin,
  input  logic                             pin_valid,
  input  logic [PIN_W-1:0]                 pin_in,
  input  logic                             amt_valid,
  input  logic [AMT_W-1:0]                 amt_in,
  input  logic [AMT_W-1:0]                 balance,
  input  logic                             note_ready,
  output logic                             note_valid,
  output logic                             balance_wr,
  output logic [AMT_W-1:0]                 balance_new,
  output logic                             pin_error,
  output logic                             amt_error,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             timeout,
  output logic                             eject,
  output logic                             card_retain
);

  localparam int TW     = $clog2(MAX_TRIES + 1);
  localparam int NOTE_W = AMT_W - NOTE_SHIFT;
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  atm_state_t         state_q;
  logic [NOTE_W-1:0]  notes_q;
  logic [TW-1:0]      tries_q;
  logic [AMT_W-1:0]   balance_new_q;
  logic               note_valid_q;
  logic               balance_wr_q;
  logic               pin_error_q;
  logic               amt_error_q;
  logic               timeout_q;
  logic               eject_q;
  logic               retain_q;

  logic timer_run;
  logic timer_clear;
  logic timer_expired;
  logic amt_accept;

  assign timer_run   = (state_q == ST_WAIT_PIN) || (state_q == ST_WAIT_AMT);
  assign timer_clear = (state_q == ST_IDLE) ||
                       ((state_q == ST_WAIT_PIN) && pin_valid) ||
                       ((state_q == ST_WAIT_AMT) && amt_valid);
  assign amt_accept  = amt_ok(32'(amt_in), 32'(balance), NOTE_SHIFT);

  atm_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // Session FSM with registered outputs; card removal outranks keypad input, which outranks the timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      notes_q       <= '0;
      tries_q       <= TRIES_MAX;
      balance_new_q <= '0;
      note_valid_q  <= 1'b0;
      balance_wr_q  <= 1'b0;
      pin_error_q   <= 1'b0;
      amt_error_q   <= 1'b0;
      timeout_q     <= 1'b0;
      eject_q       <= 1'b0;
      retain_q      <= 1'b0;
    end else begin
      balance_wr_q <= 1'b0;
      pin_error_q  <= 1'b0;
      amt_error_q  <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (card_inserted) begin
            state_q <= ST_WAIT_PIN;
            tries_q <= TRIES_MAX;
          end
        end
        ST_WAIT_PIN: begin
          if (!card_inserted) begin
            state_q <= ST_IDLE;
          end else if (pin_valid) begin
            if (pin_in == card_pin) begin
              state_q <= ST_WAIT_AMT;
              tries_q <= TRIES_MAX;
            end else begin
              pin_error_q <= 1'b1;
              tries_q     <= tries_q - TW'(1);
              if (tries_q == TW'(1)) begin
                state_q  <= ST_RETAIN;
                retain_q <= 1'b1;
              end
            end
          end else if (timer_expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_EJECT;
            eject_q   <= 1'b1;
          end
        end
        ST_WAIT_AMT: begin
          if (!card_inserted) begin
            state_q <= ST_IDLE;
          end else if (amt_valid) begin
            if (amt_accept) begin
              notes_q       <= amt_in[AMT_W-1:NOTE_SHIFT];
              balance_new_q <= balance - amt_in;
              balance_wr_q  <= 1'b1;
              note_valid_q  <= 1'b1;
              state_q       <= ST_DISPENSE;
            end else begin
              amt_error_q <= 1'b1;
            end
          end else if (timer_expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_EJECT;
            eject_q   <= 1'b1;
          end
        end
        ST_DISPENSE: begin
          if (note_valid_q && note_ready) begin
            notes_q <= notes_q - NOTE_W'(1);
            if (notes_q == NOTE_W'(1)) begin
              note_valid_q <= 1'b0;
              state_q      <= ST_EJECT;
              eject_q      <= 1'b1;
            end
          end
        end
        ST_EJECT: begin
          if (!card_inserted) begin
            eject_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RETAIN: begin
          if (!card_inserted) begin
            retain_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          note_valid_q <= 1'b0;
          eject_q      <= 1'b0;
          retain_q     <= 1'b0;
        end
      endcase
    end
  end

  assign note_valid  = note_valid_q;
  assign balance_wr  = balance_wr_q;
  assign balance_new = balance_new_q;
  assign pin_error   = pin_error_q;
  assign amt_error   = amt_error_q;
  assign tries_left  = tries_q;
  assign timeout     = timeout_q;
  assign eject       = eject_q;
  assign card_retain = retain_q;

endmodule
